// File: rtl/pe_chain_sched_pkg.sv
// Shared constants and state encoding for the PE-chain sequencer.
package pe_chain_sched_pkg;

  localparam int DATA_SIZE = 8;
  localparam int K         = 5;
  localparam int ICH       = 1;
  localparam int CALCYCLE  = K * K * ICH;
  localparam int NPE       = 6;
  localparam int IDX_W     = $clog2(NPE);
  localparam int STEP_W    = $clog2(CALCYCLE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CAL   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/pe_chain_sched_skew.sv
// Valid+data delay line; one instance per PE tap builds the weight skew.
module pe_skew_line #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk_cal,
  input  logic         rst_cal,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic [DEPTH-1:0]        vld_q;
  logic [DEPTH-1:0][W-1:0] data_q;

  always_ff @(posedge clk_cal or posedge rst_cal) begin
    if (rst_cal) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      data_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign data_o = data_q[DEPTH-1];

endmodule

// File: rtl/pe_chain_sched.sv
// Sequencer for one chain of pass-through conv PEs: issues CALCYCLE beats per
// group, skews weights per PE, then flushes and drains results off the chain end.
module pe_chain_sched
  import pe_chain_sched_pkg::*;
#(
  parameter int NGROUP = 96,
  parameter int ADDR_W = 12
) (
  input  logic                        clk_cal,
  input  logic                        rst_cal,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  input  logic                        src_rdy,
  output logic [ADDR_W-1:0]           w_addr,
  output logic [ADDR_W-1:0]           m_addr,
  output logic                        rd_en,
  input  logic [DATA_SIZE-1:0]        w_rdata,
  output logic                        pe_mvld,
  output logic [NPE-1:0]              pe_wvld,
  output logic [NPE*DATA_SIZE-1:0]    pe_wdata,
  output logic                        pe_shift,
  output logic                        res_vld,
  output logic [IDX_W-1:0]            res_idx,
  output logic [$clog2(NGROUP)-1:0]   grp_idx
);

  localparam int GRP_W = $clog2(NGROUP);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [GRP_W-1:0]    grp_q, grp_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                issue;
  logic                mvld_q;
  logic [NPE-1:0]      vld_tap;
  logic [DATA_SIZE-1:0] data_tap [NPE];

  always_ff @(posedge clk_cal or posedge rst_cal) begin
    if (rst_cal) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      grp_q   <= '0;
      base_q  <= '0;
      mvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      grp_q   <= grp_d;
      base_q  <= base_d;
      mvld_q  <= issue;
    end
  end

  // cnt_q is shared: flush wait in FLUSH, drain position in DRAIN.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    grp_d   = grp_q;
    base_d  = base_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          step_d  = '0;
          cnt_d   = '0;
          grp_d   = '0;
          base_d  = '0;
          state_d = ST_CAL;
        end
      end
      ST_CAL: begin
        if (src_rdy) begin
          issue = 1'b1;
          if (step_q == STEP_W'(CALCYCLE - 1)) begin
            step_d  = '0;
            cnt_d   = '0;
            state_d = ST_FLUSH;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (cnt_q == IDX_W'(NPE - 1)) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == IDX_W'(NPE - 1)) begin
          cnt_d = '0;
          if (grp_q == GRP_W'(NGROUP - 1)) begin
            state_d = ST_DONE;
          end else begin
            grp_d   = grp_q + 1'b1;
            base_d  = base_q + ADDR_W'(CALCYCLE);
            state_d = ST_CAL;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign rd_en    = issue;
  assign w_addr   = ADDR_W'(step_q);
  assign m_addr   = base_q + ADDR_W'(step_q);
  assign res_vld  = (state_q == ST_DRAIN);
  assign res_idx  = res_vld ? (IDX_W'(NPE - 1) - cnt_q) : '0;
  // The last drain cycle has no shift, so the chain end keeps PE0's result.
  assign pe_shift = res_vld && (cnt_q != IDX_W'(NPE - 1));
  assign grp_idx  = grp_q;
  assign pe_mvld  = mvld_q;

  // Weight data for PE0 arrives with its valid; each later PE sees both one cycle later.
  assign vld_tap[0]  = mvld_q;
  assign data_tap[0] = w_rdata;

  for (genvar k = 1; k < NPE; k++) begin : g_skew
    pe_skew_line #(.W(DATA_SIZE), .DEPTH(1)) u_skew (
      .clk_cal (clk_cal),
      .rst_cal (rst_cal),
      .vld_i   (vld_tap[k-1]),
      .data_i  (data_tap[k-1]),
      .vld_o   (vld_tap[k]),
      .data_o  (data_tap[k])
    );
  end

  for (genvar k = 0; k < NPE; k++) begin : g_wdata
    assign pe_wdata[k*DATA_SIZE +: DATA_SIZE] = data_tap[k];
  end

  assign pe_wvld = vld_tap;

endmodule

// File: tb/tb_pe_chain_sched.sv
// Bench for pe_chain_sched: directed table, schedule-model runs, async reset.
module tb_pe_chain_sched;
  import pe_chain_sched_pkg::*;

  localparam int NG   = 2;
  localparam int AW   = 12;
  localparam int MAXC = 400;

  logic                     clk_cal = 1'b0;
  logic                     rst_cal, start, src_rdy;
  logic [DATA_SIZE-1:0]     w_rdata;
  logic                     busy, done, rd_en, pe_mvld, pe_shift, res_vld;
  logic [AW-1:0]            w_addr, m_addr;
  logic [NPE-1:0]           pe_wvld;
  logic [NPE*DATA_SIZE-1:0] pe_wdata;
  logic [IDX_W-1:0]         res_idx;
  logic [$clog2(NG)-1:0]    grp_idx;

  pe_chain_sched #(.NGROUP(NG), .ADDR_W(AW)) dut (
    .clk_cal (clk_cal), .rst_cal (rst_cal), .start (start), .busy (busy),
    .done (done), .src_rdy (src_rdy), .w_addr (w_addr), .m_addr (m_addr),
    .rd_en (rd_en), .w_rdata (w_rdata), .pe_mvld (pe_mvld), .pe_wvld (pe_wvld),
    .pe_wdata (pe_wdata), .pe_shift (pe_shift), .res_vld (res_vld),
    .res_idx (res_idx), .grp_idx (grp_idx)
  );

  always #5 clk_cal = ~clk_cal;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Stimulus per cycle (cycle 0 = the cycle start is presented).
  bit                   rdy_a [MAXC];
  bit                   st_a  [MAXC];
  logic [DATA_SIZE-1:0] wr_a  [MAXC];
  // Expected schedule derived from the group/beat/flush/drain rules.
  bit e_rd [MAXC], e_busy [MAXC], e_done [MAXC], e_rv [MAXC], e_sh [MAXC];
  int e_w [MAXC], e_m [MAXC], e_idx [MAXC], e_grp [MAXC];
  int c_done;
  int last_g = 0;
  bit seq_en = 1'b0;
  int wv_cnt [NPE];
  int rv_cnt, done_cnt, end0_c;

  typedef struct {
    int cyc; bit rd; int maddr; bit wv5; bit rv; int ridx; bit dn; bit bsy;
  } vec_t;
  vec_t tbl [15];

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      rdy_a[i] = 1'b1;
      st_a[i]  = 1'b0;
      wr_a[i]  = DATA_SIZE'($urandom);
    end
    st_a[0] = 1'b1;
  endtask

  task automatic build_model(input int prev_g);
    int c, b;
    for (int i = 0; i < MAXC; i++) begin
      e_rd[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_rv[i] = 0; e_sh[i] = 0;
      e_w[i] = 0; e_idx[i] = 0; e_grp[i] = NG - 1; e_m[i] = (NG - 1) * CALCYCLE;
    end
    e_grp[0] = prev_g;
    e_m[0]   = prev_g * CALCYCLE;
    c = 1;
    for (int g = 0; g < NG; g++) begin
      b = 0;
      while (b < CALCYCLE && c < MAXC - 2 * NPE - 4) begin
        e_busy[c] = 1; e_grp[c] = g; e_w[c] = b; e_m[c] = g * CALCYCLE + b;
        e_rd[c] = rdy_a[c];
        if (rdy_a[c]) b++;
        c++;
      end
      for (int i = 0; i < 2 * NPE; i++) begin
        e_busy[c] = 1; e_grp[c] = g; e_m[c] = g * CALCYCLE;
        if (i >= NPE) begin
          e_rv[c] = 1; e_idx[c] = 2 * NPE - 1 - i; e_sh[c] = (i < 2 * NPE - 1);
        end
        c++;
      end
    end
    e_busy[c] = 1; e_done[c] = 1;
    c_done = c;
  endtask

  task automatic run_check(input int ncyc);
    logic [NPE-1:0] ewv;
    int wseq [NPE];
    int idx;
    for (int k = 0; k < NPE; k++) begin wv_cnt[k] = 0; wseq[k] = 0; end
    rv_cnt = 0; done_cnt = 0; end0_c = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk_cal);
      start = st_a[c]; src_rdy = rdy_a[c]; w_rdata = wr_a[c];
      #1;
      for (int k = 0; k < NPE; k++) begin
        idx = c - 1 - k;
        ewv[k] = (idx >= 0) ? e_rd[idx] : 1'b0;
      end
      chk($sformatf("rd_en@%0d", c), rd_en, e_rd[c]);
      chk($sformatf("w_addr@%0d", c), w_addr, e_w[c]);
      chk($sformatf("m_addr@%0d", c), m_addr, e_m[c]);
      chk($sformatf("busy@%0d", c), busy, e_busy[c]);
      chk($sformatf("done@%0d", c), done, e_done[c]);
      chk($sformatf("res_vld@%0d", c), res_vld, e_rv[c]);
      chk($sformatf("res_idx@%0d", c), res_idx, e_idx[c]);
      chk($sformatf("pe_shift@%0d", c), pe_shift, e_sh[c]);
      chk($sformatf("grp_idx@%0d", c), grp_idx, e_grp[c]);
      chk($sformatf("pe_mvld@%0d", c), pe_mvld, (c >= 1) ? e_rd[c-1] : 1'b0);
      chk($sformatf("pe_wvld@%0d", c), pe_wvld, ewv);
      for (int k = 0; k < NPE; k++) begin
        if (c >= k)
          chk($sformatf("pe_wdata%0d@%0d", k, c), pe_wdata[k*DATA_SIZE +: DATA_SIZE], wr_a[c-k]);
        if (pe_wvld[k] === 1'b1) begin
          wv_cnt[k]++;
          if (seq_en) begin
            chk($sformatf("wseq%0d@%0d", k, c), pe_wdata[k*DATA_SIZE +: DATA_SIZE],
                (wseq[k] % CALCYCLE) + 1);
            wseq[k]++;
          end
        end
      end
      if (res_vld === 1'b1) rv_cnt++;
      if (done === 1'b1) done_cnt++;
      if (res_vld === 1'b1 && res_idx == 0 && end0_c < 0) end0_c = c;
    end
    start = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);     chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);   chk({tag, "_res_vld"}, res_vld, 0);
    chk({tag, "_shift"}, pe_shift, 0); chk({tag, "_mvld"}, pe_mvld, 0);
    chk({tag, "_wvld"}, pe_wvld, 0);  chk({tag, "_w_addr"}, w_addr, 0);
    chk({tag, "_m_addr"}, m_addr, 0); chk({tag, "_grp"}, grp_idx, 0);
    chk({tag, "_res_idx"}, res_idx, 0); chk({tag, "_wdata"}, pe_wdata, 0);
  endtask

  task automatic check_counts(input string tag, input int exp_end0);
    for (int k = 0; k < NPE; k++) chk($sformatf("%s_wvld_cnt%0d", tag, k), wv_cnt[k], NG * CALCYCLE);
    chk({tag, "_res_cnt"}, rv_cnt, NG * NPE);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    if (exp_end0 > 0) chk({tag, "_grp_len"}, end0_c, exp_end0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p, c;
    rst_cal = 1'b1; start = 1'b0; src_rdy = 1'b0; w_rdata = '0;
    repeat (3) @(negedge clk_cal);
    #1;
    check_idle_zero("reset");
    @(negedge clk_cal);
    rst_cal = 1'b0;

    // Directed no-stall run: {cycle, rd_en, m_addr, pe_wvld[5], res_vld, res_idx, done, busy}
    tbl = '{
      '{0,  1'b0, 0,  1'b0, 1'b0, 0, 1'b0, 1'b0},
      '{1,  1'b1, 0,  1'b0, 1'b0, 0, 1'b0, 1'b1},
      '{6,  1'b1, 5,  1'b0, 1'b0, 0, 1'b0, 1'b1},
      '{7,  1'b1, 6,  1'b1, 1'b0, 0, 1'b0, 1'b1},
      '{25, 1'b1, 24, 1'b1, 1'b0, 0, 1'b0, 1'b1},
      '{26, 1'b0, 0,  1'b1, 1'b0, 0, 1'b0, 1'b1},
      '{31, 1'b0, 0,  1'b1, 1'b0, 0, 1'b0, 1'b1},
      '{32, 1'b0, 0,  1'b0, 1'b1, 5, 1'b0, 1'b1},
      '{37, 1'b0, 0,  1'b0, 1'b1, 0, 1'b0, 1'b1},
      '{38, 1'b1, 25, 1'b0, 1'b0, 0, 1'b0, 1'b1},
      '{62, 1'b1, 49, 1'b1, 1'b0, 0, 1'b0, 1'b1},
      '{69, 1'b0, 25, 1'b0, 1'b1, 5, 1'b0, 1'b1},
      '{74, 1'b0, 25, 1'b0, 1'b1, 0, 1'b0, 1'b1},
      '{75, 1'b0, 25, 1'b0, 1'b0, 0, 1'b1, 1'b1},
      '{76, 1'b0, 25, 1'b0, 1'b0, 0, 1'b0, 1'b0}
    };
    p = 0;
    for (c = 0; c < 78; c++) begin
      @(negedge clk_cal);
      start = (c == 0); src_rdy = 1'b1; w_rdata = DATA_SIZE'($urandom);
      #1;
      if (p < 15 && tbl[p].cyc == c) begin
        chk($sformatf("tbl_rd_en@%0d", c), rd_en, tbl[p].rd);
        chk($sformatf("tbl_m_addr@%0d", c), m_addr, tbl[p].maddr);
        chk($sformatf("tbl_wvld5@%0d", c), pe_wvld[5], tbl[p].wv5);
        chk($sformatf("tbl_res_vld@%0d", c), res_vld, tbl[p].rv);
        chk($sformatf("tbl_res_idx@%0d", c), res_idx, tbl[p].ridx);
        chk($sformatf("tbl_done@%0d", c), done, tbl[p].dn);
        chk($sformatf("tbl_busy@%0d", c), busy, tbl[p].bsy);
        p++;
      end
    end
    start = 1'b0;
    last_g = NG - 1;

    // Two-cycle stalls at steps 3 and 17; weights fed as 1..25 by address.
    clear_stim();
    c = 1;
    for (int g = 0; g < NG; g++) begin
      for (int b = 0; b < CALCYCLE; b++) begin
        if (b == 3 || b == 17) begin rdy_a[c] = 1'b0; rdy_a[c+1] = 1'b0; c += 2; end
        rdy_a[c] = 1'b1; c++;
      end
      for (int i = 0; i < 2 * NPE; i++) begin rdy_a[c] = 1'($urandom); c++; end
    end
    build_model(last_g);
    for (int i = 1; i < MAXC; i++)
      if (e_rd[i-1]) wr_a[i] = DATA_SIZE'(e_w[i-1] + 1);
    seq_en = 1'b1;
    run_check(c_done + 3);
    seq_en = 1'b0;
    check_counts("stall", 41);

    // start re-pulsed during CAL, DRAIN and second-group CAL.
    clear_stim();
    st_a[5] = 1'b1; st_a[34] = 1'b1; st_a[50] = 1'b1;
    build_model(last_g);
    run_check(c_done + 3);
    check_counts("restart", 37);

    // Long continuous stall inside CAL.
    clear_stim();
    for (int i = 11; i < 41; i++) rdy_a[i] = 1'b0;
    build_model(last_g);
    run_check(c_done + 3);
    check_counts("longstall", 67);

    // Random readiness and stray start pulses.
    for (int r = 0; r < 3; r++) begin
      clear_stim();
      for (int i = 1; i < MAXC; i++) rdy_a[i] = ($urandom_range(9) < 7);
      build_model(last_g);
      if (c_done > MAXC - 5) begin
        errors++;
        $display("FAIL rand_model: schedule too long (%0d cycles, limit %0d)", c_done, MAXC - 5);
      end else begin
        for (int j = 0; j < 4; j++) st_a[$urandom_range(c_done, 1)] = 1'b1;
        run_check(c_done + 3);
        check_counts($sformatf("rand%0d", r), 0);
      end
    end

    // Asynchronous reset in the middle of group 1's drain.
    clear_stim();
    build_model(last_g);
    run_check(72);
    src_rdy = 1'b0; w_rdata = '0;
    #2 rst_cal = 1'b1;
    #1;
    check_idle_zero("async_rst");
    @(negedge clk_cal);
    rst_cal = 1'b0;
    last_g = 0;

    // Fresh start after the reset must reproduce the clean schedule.
    clear_stim();
    build_model(last_g);
    run_check(c_done + 3);
    check_counts("after_rst", 37);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_chain_sched.md
Name: pe_chain_sched

Overview:
- Sequencer for one chain of NPE pass-through conv PEs.
- Map data enters PE0 and ripples PE to PE. Weights are broadcast with a per-PE skew. Results drain out of the last PE through the dout/din pass chain.
- Generates weight/map buffer addresses and issues exactly CALCYCLE valid beats per output group, so every PE's internal beat counter stays aligned.
- Sits between the weight/map buffers and the PE chain. Reports each drained result to the output writer.

Parameters:
- DATA_SIZE, 8, data width.
- K, 5, kernel size.
- ICH, 1, input channels.
- CALCYCLE, K*K*ICH (25), beats per output group.
- NPE, 6, PEs in chain (>=2, CALCYCLE>NPE).
- NGROUP, 96, output groups per layer.
- ADDR_W, 12, buffer address width.

Ports:
- clk_cal  in  1  clock.
- rst_cal  in  1  asynchronous active-high reset.
- start  in  1  layer start pulse; ignored unless idle.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at layer end.
- src_rdy  in  1  buffers can serve a read this cycle; low = stall.
- w_addr  out  ADDR_W  weight address = step (0..CALCYCLE-1).
- m_addr  out  ADDR_W  map address = grp*CALCYCLE + step.
- rd_en  out  1  beat issued this cycle.
- w_rdata  in  DATA_SIZE  weight read data, 1 cycle after rd_en.
- pe_mvld  out  1  ImapVld to PE0 (rd_en delayed 1).
- pe_wvld  out  NPE  IweightVld per PE; bit k = rd_en delayed 1+k.
- pe_wdata  out  NPE*DATA_SIZE  IWeight per PE; slice k = w_rdata delayed k.
- pe_shift  out  1  dinVld broadcast to all PEs.
- res_vld  out  1  chain-end dout holds a valid result.
- res_idx  out  clog2(NPE)  PE index of current result.
- grp_idx  out  clog2(NGROUP)  current group.

Behaviour:
- Reset values: all outputs 0; state IDLE; all delay lines 0.
- Reset mid-operation clears immediately. The PEs share rst_cal, so the whole chain restarts clean.
- States and transitions:
  - IDLE: on start, grp=0, step=0, go to CAL. busy=1 from the next cycle.
  - CAL: rd_en = src_rdy.
    - Each beat increments step.
    - On the beat with step==CALCYCLE-1: step=0, go to FLUSH, fcnt=0.
    - src_rdy=0 inserts a bubble. The bubble propagates through every skew line, so each PE still receives exactly CALCYCLE valids.
  - FLUSH: wait NPE cycles, so the last PE's dout is loaded. No rd_en. Then go to DRAIN, dcnt=0.
  - DRAIN: NPE cycles.
    - res_vld=1, res_idx=NPE-1-dcnt.
    - pe_shift=1 for dcnt<NPE-1.
    - After the last cycle: if grp==NGROUP-1 go to DONE, else grp+1 and go to CAL.
  - DONE: done=1 for one cycle, busy=0 next cycle, go to IDLE.
- Timing: cycles per group, with no stalls, = CALCYCLE+2*NPE.
- pe_shift must never coincide with any PE's final valid beat. FLUSH length guarantees this because din has priority in the PE.
- No overlap between groups. CAL of the next group starts only after DRAIN.
- start while busy is ignored.
- src_rdy toggling in FLUSH/DRAIN has no effect.
- Addresses hold their value during stalls.
- Width rules:
  - m_addr is computed by a running base register (+CALCYCLE per group), not a multiplier.
  - Counters wrap only at the stated terminal values.

Decomposition:
- Shared package holds DATA_SIZE, K, ICH, CALCYCLE, NPE, and the state encoding (IDLE/CAL/FLUSH/DRAIN/DONE).
- One natural sub-module: pe_skew_line. It is a parameterised valid+data delay line instantiated per PE tap. Alternatively, one NPE-deep shift register with taps.

Test Plan:
1. Reset, start, src_rdy=1, NGROUP=2:
   - rd_en high 25 cycles, m_addr 0..24 then 25..49.
   - pe_wvld[5] first high 6 cycles after the first rd_en.
   - res_vld 6 cycles per group, res_idx 5,4,3,2,1,0.
   - done 74 cycles after the first CAL cycle.
2. src_rdy low at steps 3 and 17 for 2 cycles each:
   - exactly 25 pe_wvld pulses per bit.
   - each PE result equals the golden conv value; group length 41 cycles.
3. Weights 1..25, all maps 8 (Q4.3 = 1.0), bias 0: every res-value equals saturated/rounded golden, and the 6 results are identical.
4. start re-pulsed during CAL and DRAIN: ignored; grp_idx and addresses unaffected; single done.
5. rst_cal asserted mid-DRAIN of group 1:
   - all outputs 0 asynchronously.
   - a fresh start produces group 0 results identical to scenario 1.
6. Continuous src_rdy=0 in CAL: state, step and addresses hold; no pe_* valids; busy stays 1.
